alarm_ctrl: RTL and testbench
=============================

// Module: alarm_ctrl
// PURPOSE
//  Alarm engine downstream of the alarm-time button handler. Compares the running clock
//  time with the stored alarm time (a_hour/a_min), rings a pulsed buzzer, and handles
//  stop, snooze and ring-timeout. Feeds the buzzer pin and the alarm status LEDs.
// PARAMETERS
//  RING_SEC    60  seconds of ringing before auto-stop (>=1)
//  SNOOZE_MIN  5   snooze length in minutes (>=1); countdown = SNOOZE_MIN*60 ticks
//  MAX_SNOOZE  3   snoozes allowed per alarm event; further snooze presses act as stop
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous reset, active-high
//  enb         in   1  clock enable; low = all state, counters and outputs hold
//  tick_1hz    in   1  one-clk pulse per second from the timebase
//  sw0         in   1  alarm armed (1) / disarmed (0)
//  btn_stop    in   1  one-clk pulse from the edge detector: stop ringing/snooze
//  btn_snooze  in   1  one-clk pulse from the edge detector: snooze
//  cur_hour    in   6  current time hours, 0..23
//  cur_min     in   6  current time minutes, 0..59
//  cur_sec     in   6  current time seconds, 0..59
//  a_hour      in   6  alarm hours, 0..23
//  a_min       in   6  alarm minutes, 0..59
//  buzzer      out  1  buzzer drive, 1 Hz on/off pattern while ringing
//  ringing     out  1  state == RINGING
//  snoozed     out  1  state == SNOOZE
//  snooze_cnt  out  2  snoozes used in the current event
// BEHAVIOUR
//  - Reset: state=IDLE; buzzer=0, ringing=0, snoozed=0, snooze_cnt=0; counters=0; beep=0.
//  - All updates gated by enb; with enb=0 nothing changes, including timeout counters.
//  - match = sw0 & tick_1hz & cur_sec==0 & cur_hour==a_hour & cur_min==a_min.
//  - IDLE -> RINGING on match. Register next edge; ring_cnt=RING_SEC; beep=1; snooze_cnt=0.
//  - RINGING: on each tick, ring_cnt decrements and beep toggles. buzzer = beep (registered).
//  - RINGING -> IDLE: on btn_stop, or on a tick when ring_cnt==1 (timeout). Total ring
//    time is RING_SEC ticks. snooze_cnt is cleared.
//  - RINGING -> SNOOZE on btn_snooze when snooze_cnt<MAX_SNOOZE. Load snz_cnt=SNOOZE_MIN*60
//    and increment snooze_cnt. If snooze_cnt==MAX_SNOOZE, treat btn_snooze as btn_stop.
//  - SNOOZE: snz_cnt decrements per tick. On a tick with snz_cnt==1 -> RINGING. Reload
//    ring_cnt and set beep=1. btn_stop -> IDLE. btn_snooze is ignored.
//  - The alarm time is not re-matched while in RINGING or SNOOZE. Changing a_hour/a_min
//    mid-snooze does not alter the pending re-ring.
//  - Disarm: sw0=0 in any state -> IDLE next edge, outputs cleared. This has priority over
//    all other events.
//  - Simultaneous btn_stop & btn_snooze: stop wins. A button pulse coincident with the
//    timeout tick uses the button action.
//  - No re-trigger after stop within the alarm minute; match requires cur_sec==0.
//  - Counter widths are $clog2(max load + 1). No wrap: counters are only decremented from
//    values >=1.
//  - buzzer, ringing and snoozed are registered. They change one clk after the causing
//    event. buzzer is 0 in every state except RINGING.
// STRUCTURE
//  - Shared header clock_defs.vh holds MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59 and the state
//    encodings IDLE=2'd0, RINGING=2'd1, SNOOZE=2'd2. buttons and the timekeeper use the
//    same header.
//  - One sub-module: sec_countdown (load, load value, tick, enb; outputs count and
//    done==count is 1 at tick). It is instantiated twice, for the ring timer and the
//    snooze timer.
// TESTING  (RING_SEC=4, SNOOZE_MIN=1, MAX_SNOOZE=2, tick every 10 clk)
//  - Alarm 07:30, sw0=1, time reaches 07:30:00 -> ringing=1 one clk after the tick.
//    buzzer reads 1,0,1,0 over the next 4 ticks, then ringing=0 (timeout).
//  - Ringing, then btn_snooze -> snoozed=1, snooze_cnt=1. 60 ticks later ringing=1 again.
//    btn_stop -> IDLE, snooze_cnt=0.
//  - Snooze twice, then btn_snooze on the third ring -> IDLE. snoozed stays 0.
//  - btn_stop and btn_snooze in the same clk while ringing -> IDLE.
//  - sw0=0 at 07:30:00 -> no ring. sw0 dropped mid-SNOOZE -> IDLE next clk, no re-ring.
//  - rst asserted mid-RINGING, asynchronously -> all outputs 0 immediately. enb=0 for
//    20 ticks during SNOOZE -> re-ring delayed by exactly those ticks.

Source files
------------

// File: rtl/alarm_ctrl_pkg.sv
// Shared definitions for the alarm engine.
// The state encoding is fixed because the status LEDs and the neighbouring
// button/timekeeper logic decode the same values.
// Contents:
//   alarm_state_e  IDLE / RINGING / SNOOZE state encoding
//   SEC_PER_MIN    ticks per minute, used to size the snooze countdown
//   time_match     hour/minute/second compare used to detect the alarm instant
package alarm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } alarm_state_e;

    localparam int SEC_PER_MIN = 60;

    // The alarm fires only at second zero, so a stop inside the alarm
    // minute cannot re-trigger it.
    function automatic logic time_match(
        input logic [5:0] cur_hour,
        input logic [5:0] cur_min,
        input logic [5:0] cur_sec,
        input logic [5:0] a_hour,
        input logic [5:0] a_min
    );
        return (cur_sec == 6'd0) && (cur_hour == a_hour) && (cur_min == a_min);
    endfunction

endpackage

// File: rtl/alarm_ctrl_sec_countdown.sv
// Per-second down counter used for both the ring timeout and the snooze delay.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   enb        clock enable; the count holds while low
//   load       load load_val on the next enabled edge (beats tick)
//   load_val   value to load
//   tick       one-clk decrement request
//   count      current count
//   done       high on the tick that brings the count from 1 to 0
module sec_countdown #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enb,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // A zero count never decrements, so the counter cannot wrap.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (enb) begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign done  = tick && (count_q == W'(1));

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm engine: watches the running time against the stored alarm time,
// rings a 1 Hz pulsed buzzer, and handles stop, snooze and ring timeout.
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   enb                   clock enable; everything holds while low
//   tick_1hz              one-clk pulse per second
//   sw0                   alarm armed; low forces IDLE with highest priority
//   btn_stop, btn_snooze  one-clk button pulses
//   cur_hour/min/sec      running time
//   a_hour, a_min         alarm time
//   buzzer                pulsed buzzer drive, only ever high in RINGING
//   ringing, snoozed      registered state flags
//   snooze_cnt            snoozes used in the current alarm event
module alarm_ctrl
    import alarm_ctrl_pkg::*;
#(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       tick_1hz,
    input  logic       sw0,
    input  logic       btn_stop,
    input  logic       btn_snooze,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [5:0] a_hour,
    input  logic [5:0] a_min,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozed,
    output logic [1:0] snooze_cnt
);

    localparam int SNZ_TICKS = SNOOZE_MIN * SEC_PER_MIN;
    localparam int RING_W    = $clog2(RING_SEC + 1);
    localparam int SNZ_W     = $clog2(SNZ_TICKS + 1);

    localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SEC);
    localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNZ_TICKS);
    localparam logic [1:0]        MAX_SNZ   = 2'(MAX_SNOOZE);

    alarm_state_e state_q, state_d;
    logic         beep_q, beep_d;
    logic [1:0]   snooze_cnt_q, snooze_cnt_d;
    logic         buzzer_q, buzzer_d;
    logic         ringing_q, ringing_d;
    logic         snoozed_q, snoozed_d;

    logic              match;
    logic              ring_load, snz_load;
    logic              ring_tick, snz_tick;
    logic              ring_done, snz_done;
    logic [RING_W-1:0] ring_cnt;
    logic [SNZ_W-1:0]  snz_cnt;

    assign match = sw0 && tick_1hz && time_match(cur_hour, cur_min, cur_sec, a_hour, a_min);

    // Each timer only sees ticks while its own state is active.
    assign ring_tick = tick_1hz && (state_q == RINGING) && (ring_cnt != '0);
    assign snz_tick  = tick_1hz && (state_q == SNOOZE) && (snz_cnt != '0);

    sec_countdown #(.W(RING_W)) u_ring_timer (
        .clk      (clk),
        .rst      (rst),
        .enb      (enb),
        .load     (ring_load),
        .load_val (RING_LOAD),
        .tick     (ring_tick),
        .count    (ring_cnt),
        .done     (ring_done)
    );

    sec_countdown #(.W(SNZ_W)) u_snz_timer (
        .clk      (clk),
        .rst      (rst),
        .enb      (enb),
        .load     (snz_load),
        .load_val (SNZ_LOAD),
        .tick     (snz_tick),
        .count    (snz_cnt),
        .done     (snz_done)
    );

    // Next-state logic. Disarm beats everything; within a state, stop beats
    // snooze, and either button beats a coincident timer expiry.
    always_comb begin
        state_d      = state_q;
        beep_d       = beep_q;
        snooze_cnt_d = snooze_cnt_q;
        ring_load    = 1'b0;
        snz_load     = 1'b0;

        if (!sw0) begin
            state_d      = IDLE;
            beep_d       = 1'b0;
            snooze_cnt_d = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (match) begin
                        state_d      = RINGING;
                        ring_load    = 1'b1;
                        beep_d       = 1'b1;
                        snooze_cnt_d = 2'd0;
                    end
                end
                RINGING: begin
                    if (btn_stop) begin
                        state_d      = IDLE;
                        beep_d       = 1'b0;
                        snooze_cnt_d = 2'd0;
                    end else if (btn_snooze) begin
                        // Snoozes beyond the allowance end the event.
                        if (snooze_cnt_q < MAX_SNZ) begin
                            state_d      = SNOOZE;
                            snz_load     = 1'b1;
                            beep_d       = 1'b0;
                            snooze_cnt_d = snooze_cnt_q + 2'd1;
                        end else begin
                            state_d      = IDLE;
                            beep_d       = 1'b0;
                            snooze_cnt_d = 2'd0;
                        end
                    end else if (ring_done) begin
                        state_d      = IDLE;
                        beep_d       = 1'b0;
                        snooze_cnt_d = 2'd0;
                    end else if (ring_tick) begin
                        beep_d = ~beep_q;
                    end
                end
                SNOOZE: begin
                    if (btn_stop) begin
                        state_d      = IDLE;
                        beep_d       = 1'b0;
                        snooze_cnt_d = 2'd0;
                    end else if (snz_done) begin
                        state_d   = RINGING;
                        ring_load = 1'b1;
                        beep_d    = 1'b1;
                    end
                end
                default: begin
                    state_d      = IDLE;
                    beep_d       = 1'b0;
                    snooze_cnt_d = 2'd0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they follow the cause by one clk.
    always_comb begin
        ringing_d = (state_d == RINGING);
        snoozed_d = (state_d == SNOOZE);
        buzzer_d  = ringing_d && beep_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            beep_q       <= 1'b0;
            snooze_cnt_q <= 2'd0;
            buzzer_q     <= 1'b0;
            ringing_q    <= 1'b0;
            snoozed_q    <= 1'b0;
        end else if (enb) begin
            state_q      <= state_d;
            beep_q       <= beep_d;
            snooze_cnt_q <= snooze_cnt_d;
            buzzer_q     <= buzzer_d;
            ringing_q    <= ringing_d;
            snoozed_q    <= snoozed_d;
        end
    end

    assign buzzer     = buzzer_q;
    assign ringing    = ringing_q;
    assign snoozed    = snoozed_q;
    assign snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Testbench for alarm_ctrl with short timers (4 s ring, 1 min snooze,
// 2 snoozes) and a tick every 10 clocks. The bench acts as the timekeeper
// and keeps a behavioural model in elapsed-tick terms.
module tb_alarm_ctrl;

    localparam int RING_SEC   = 4;
    localparam int SNOOZE_MIN = 1;
    localparam int MAX_SNOOZE = 2;
    localparam int TICK_DIV   = 10;
    localparam int SNZ_TICKS  = SNOOZE_MIN * 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enb = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       sw0 = 1'b0;
    logic       btn_stop = 1'b0;
    logic       btn_snooze = 1'b0;
    logic [5:0] cur_hour = 6'd0;
    logic [5:0] cur_min = 6'd0;
    logic [5:0] cur_sec = 6'd0;
    logic [5:0] a_hour = 6'd7;
    logic [5:0] a_min = 6'd30;
    logic       buzzer, ringing, snoozed;
    logic [1:0] snooze_cnt;

    alarm_ctrl #(
        .RING_SEC   (RING_SEC),
        .SNOOZE_MIN (SNOOZE_MIN),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enb        (enb),
        .tick_1hz   (tick_1hz),
        .sw0        (sw0),
        .btn_stop   (btn_stop),
        .btn_snooze (btn_snooze),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .a_hour     (a_hour),
        .a_min      (a_min),
        .buzzer     (buzzer),
        .ringing    (ringing),
        .snoozed    (snoozed),
        .snooze_cnt (snooze_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: mode 0 = silent, 1 = ringing, 2 = snoozing.
    // ring_el / snz_el count ticks spent in the current ring / snooze.
    int m_mode   = 0;
    int m_ring_el = 0;
    int m_snz_el = 0;
    int m_used   = 0;

    task automatic modelReset();
        m_mode    = 0;
        m_ring_el = 0;
        m_snz_el  = 0;
        m_used    = 0;
    endtask

    task automatic modelEndEvent();
        m_mode = 0;
        m_used = 0;
    endtask

    task automatic modelStep();
        if (rst) begin
            modelReset();
        end else if (enb) begin
            if (!sw0) begin
                modelEndEvent();
            end else if (m_mode == 0) begin
                if (tick_1hz && cur_sec == 0 && cur_hour == a_hour && cur_min == a_min) begin
                    m_mode    = 1;
                    m_ring_el = 0;
                    m_used    = 0;
                end
            end else if (m_mode == 1) begin
                if (btn_stop) begin
                    modelEndEvent();
                end else if (btn_snooze) begin
                    if (m_used < MAX_SNOOZE) begin
                        m_mode   = 2;
                        m_snz_el = 0;
                        m_used++;
                    end else begin
                        modelEndEvent();
                    end
                end else if (tick_1hz) begin
                    m_ring_el++;
                    if (m_ring_el == RING_SEC) modelEndEvent();
                end
            end else begin
                if (btn_stop) begin
                    modelEndEvent();
                end else if (tick_1hz) begin
                    m_snz_el++;
                    if (m_snz_el == SNZ_TICKS) begin
                        m_mode    = 1;
                        m_ring_el = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        compare("ringing", {7'd0, ringing}, (m_mode == 1) ? 8'd1 : 8'd0);
        compare("snoozed", {7'd0, snoozed}, (m_mode == 2) ? 8'd1 : 8'd0);
        compare("buzzer", {7'd0, buzzer},
                (m_mode == 1 && (m_ring_el % 2) == 0) ? 8'd1 : 8'd0);
        compare("snooze_cnt", {6'd0, snooze_cnt}, 8'(m_used));
    endtask

    task automatic advanceTime();
        if (cur_sec == 6'd59) begin
            cur_sec = 6'd0;
            if (cur_min == 6'd59) begin
                cur_min  = 6'd0;
                cur_hour = (cur_hour == 6'd23) ? 6'd0 : cur_hour + 6'd1;
            end else begin
                cur_min = cur_min + 6'd1;
            end
        end else begin
            cur_sec = cur_sec + 6'd1;
        end
    endtask

    task automatic setTime(input int h, input int m, input int s);
        cur_hour = 6'(h);
        cur_min  = 6'(m);
        cur_sec  = 6'(s);
    endtask

    // One clock: drive the tick, let the edge happen, step the model, then
    // sample away from the edge and advance the bench timekeeper.
    task automatic applyStimulus();
        tick_1hz = (cyc % TICK_DIV == TICK_DIV - 1);
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
        if (tick_1hz) advanceTime();
        cyc++;
    endtask

    task automatic runTicks(input int n);
        int seen = 0;
        while (seen < n) begin
            applyStimulus();
            if (tick_1hz) seen++;
        end
    endtask

    task automatic press(input logic stop_b, input logic snooze_b);
        btn_stop   = stop_b;
        btn_snooze = snooze_b;
        applyStimulus();
        btn_stop   = 1'b0;
        btn_snooze = 1'b0;
    endtask

    // Brings the model and DUT into RINGING via a fresh 07:30:00 match.
    task automatic startRing();
        setTime(7, 29, 59);
        runTicks(2);
        compare("ring_start", {7'd0, ringing}, 8'd1);
    endtask

    initial begin
        $display("[TB] alarm_ctrl bench start");

        // Reset values
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        compare("reset_buzzer", {7'd0, buzzer}, 8'd0);
        compare("reset_cnt", {6'd0, snooze_cnt}, 8'd0);
        rst = 1'b0;
        sw0 = 1'b1;

        // Ring then timeout after RING_SEC ticks, buzzer 1,0,1,0
        setTime(7, 29, 58);
        runTicks(3);
        compare("t1_ringing", {7'd0, ringing}, 8'd1);
        compare("t1_buzzer", {7'd0, buzzer}, 8'd1);
        runTicks(4);
        compare("t1_timeout", {7'd0, ringing}, 8'd0);
        runTicks(2);

        // Snooze, re-ring after a full snooze, then stop
        startRing();
        press(1'b0, 1'b1);
        compare("t2_snoozed", {7'd0, snoozed}, 8'd1);
        compare("t2_cnt", {6'd0, snooze_cnt}, 8'd1);
        runTicks(SNZ_TICKS);
        compare("t2_rering", {7'd0, ringing}, 8'd1);
        press(1'b1, 1'b0);
        compare("t2_stop_cnt", {6'd0, snooze_cnt}, 8'd0);
        runTicks(2);

        // Third snooze press acts as stop
        startRing();
        press(1'b0, 1'b1);
        runTicks(SNZ_TICKS);
        press(1'b0, 1'b1);
        runTicks(SNZ_TICKS);
        compare("t3_third_ring", {7'd0, ringing}, 8'd1);
        press(1'b0, 1'b1);
        compare("t3_snoozed", {7'd0, snoozed}, 8'd0);
        compare("t3_ringing", {7'd0, ringing}, 8'd0);
        runTicks(3);

        // Both buttons together: stop wins
        startRing();
        press(1'b1, 1'b1);
        compare("t4_both", {7'd0, snoozed}, 8'd0);
        runTicks(2);

        // Disarmed at the alarm instant, then disarm mid-snooze
        sw0 = 1'b0;
        setTime(7, 29, 59);
        runTicks(3);
        compare("t5_no_ring", {7'd0, ringing}, 8'd0);
        sw0 = 1'b1;
        startRing();
        press(1'b0, 1'b1);
        runTicks(10);
        sw0 = 1'b0;
        applyStimulus();
        compare("t5_disarm", {7'd0, snoozed}, 8'd0);
        sw0 = 1'b1;
        runTicks(SNZ_TICKS);

        // Asynchronous reset mid-ring
        startRing();
        runTicks(1);
        #2;
        rst = 1'b1;
        #1;
        compare("t6_rst_ringing", {7'd0, ringing}, 8'd0);
        compare("t6_rst_buzzer", {7'd0, buzzer}, 8'd0);
        modelReset();
        applyStimulus();
        rst = 1'b0;
        runTicks(2);

        // Enable held low during snooze delays the re-ring; alarm change ignored
        startRing();
        press(1'b0, 1'b1);
        runTicks(10);
        a_min = 6'd45;
        enb = 1'b0;
        runTicks(20);
        enb = 1'b1;
        runTicks(SNZ_TICKS - 11);
        compare("t7_still_snooze", {7'd0, snoozed}, 8'd1);
        runTicks(1);
        compare("t7_rering", {7'd0, ringing}, 8'd1);
        press(1'b1, 1'b0);
        a_min = 6'd30;

        // Randomized stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            if (m_mode == 0 && (i % 400) == 0) setTime(7, 29, 50 + int'($urandom_range(0, 8)));
            btn_stop   = ($urandom_range(0, 59) == 0);
            btn_snooze = ($urandom_range(0, 29) == 0);
            enb        = ($urandom_range(0, 19) != 0);
            sw0        = ($urandom_range(0, 299) != 0);
            applyStimulus();
        end
        btn_stop   = 1'b0;
        btn_snooze = 1'b0;
        enb        = 1'b1;
        sw0        = 1'b1;
        runTicks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
